// File: rtl/lsu_master_pkg.sv
// lsu_master_pkg: shared size, cause and state encodings for the load/store unit.
// Revision: 1.0
`default_nettype none

package lsu_master_pkg;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  localparam logic [1:0] CAUSE_OK       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ACCESS   = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// lsu_align: request legality checks, store data masking and load data extension.
// Revision: 1.0
`default_nettype none

module lsu_align
  import lsu_master_pkg::*;
(
  input  logic        chk_store_i,
  input  logic [2:0]  chk_funct3_i,
  input  logic [1:0]  chk_addr_lo_i,
  input  logic [31:0] chk_wdata_i,
  input  logic [2:0]  ext_funct3_i,
  input  logic [31:0] ext_rdata_i,
  output logic        illegal_o,
  output logic        misalign_o,
  output logic [31:0] wmask_o,
  output logic [31:0] rext_o
);

  logic w_sext;

  // An unsigned store is meaningless, so funct3[2] on a store is treated as illegal.
  always_comb begin
    illegal_o  = (chk_funct3_i[1:0] == 2'b11) || (chk_store_i && chk_funct3_i[2]);
    misalign_o = 1'b0;
    wmask_o    = chk_wdata_i;
    case (chk_funct3_i[1:0])
      LEN_B: wmask_o = {24'b0, chk_wdata_i[7:0]};
      LEN_H: begin
        misalign_o = chk_addr_lo_i[0];
        wmask_o    = {16'b0, chk_wdata_i[15:0]};
      end
      LEN_W:   misalign_o = (chk_addr_lo_i != 2'b00);
      default: misalign_o = 1'b0;
    endcase
  end

  always_comb begin
    w_sext = ~ext_funct3_i[2];
    case (ext_funct3_i[1:0])
      LEN_B:   rext_o = {{24{w_sext & ext_rdata_i[7]}}, ext_rdata_i[7:0]};
      LEN_H:   rext_o = {{16{w_sext & ext_rdata_i[15]}}, ext_rdata_i[15:0]};
      default: rext_o = ext_rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_master.sv
// lsu_master: single-outstanding load/store initiator for the core data bus.
// Revision: 1.0
`default_nettype none

module lsu_master
  import lsu_master_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_cause,
  output logic        bus_rw,
  output logic [1:0]  bus_len,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write,
  input  logic [31:0] bus_read,
  input  logic        bus_exception
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  bus_len_q, bus_len_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_write_q, bus_write_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_cause_q, resp_cause_d;

  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_wmask;
  logic [31:0] w_rext;

  lsu_align u_align (
    .chk_store_i   (req_store),
    .chk_funct3_i  (req_funct3),
    .chk_addr_lo_i (req_addr[1:0]),
    .chk_wdata_i   (req_wdata),
    .ext_funct3_i  (funct3_q),
    .ext_rdata_i   (bus_read),
    .illegal_o     (w_illegal),
    .misalign_o    (w_misalign),
    .wmask_o       (w_wmask),
    .rext_o        (w_rext)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    bus_len_d    = bus_len_q;
    bus_addr_d   = bus_addr_q;
    bus_write_d  = bus_write_q;
    resp_rdata_d = resp_rdata_q;
    resp_cause_d = resp_cause_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          // Locally detected faults skip the bus entirely; illegal wins over misaligned.
          if (w_illegal) begin
            state_d      = ST_RESP;
            resp_cause_d = CAUSE_ILLEGAL;
            resp_rdata_d = 32'b0;
          end else if (w_misalign) begin
            state_d      = ST_RESP;
            resp_cause_d = CAUSE_MISALIGN;
            resp_rdata_d = 32'b0;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = WAIT_INIT;
            bus_len_d   = req_funct3[1:0];
            bus_addr_d  = req_addr;
            bus_write_d = w_wmask;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          if (bus_exception) begin
            resp_cause_d = CAUSE_ACCESS;
            resp_rdata_d = 32'b0;
          end else begin
            resp_cause_d = CAUSE_OK;
            resp_rdata_d = store_q ? 32'b0 : w_rext;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      store_q      <= 1'b0;
      funct3_q     <= 3'b0;
      bus_len_q    <= 2'b0;
      bus_addr_q   <= 32'b0;
      bus_write_q  <= 32'b0;
      resp_rdata_q <= 32'b0;
      resp_cause_q <= CAUSE_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      bus_len_q    <= bus_len_d;
      bus_addr_q   <= bus_addr_d;
      bus_write_q  <= bus_write_d;
      resp_rdata_q <= resp_rdata_d;
      resp_cause_q <= resp_cause_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  // Write strobe only while the access is live so idle address/data never trigger an io write.
  assign bus_rw     = (state_q == ST_ACCESS) && store_q;
  assign bus_len    = bus_len_q;
  assign bus_addr   = bus_addr_q;
  assign bus_write  = bus_write_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_cause = resp_cause_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_master.sv
// tb_lsu_master: directed vector table, reset abort sequence and randomized model check.
`default_nettype none

module tb_lsu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid0;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, bus_read;
  logic        bus_exception;

  logic        req_ready, resp_valid, bus_rw;
  logic [31:0] resp_rdata, bus_addr, bus_write;
  logic [1:0]  resp_cause, bus_len;

  logic        req_ready_z, resp_valid_z, bus_rw_z;
  logic [31:0] resp_rdata_z, bus_addr_z, bus_write_z;
  logic [1:0]  resp_cause_z, bus_len_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_master #(.WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_cause(resp_cause),
    .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_read(bus_read), .bus_exception(bus_exception)
  );

  lsu_master #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready_z),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_z), .resp_rdata(resp_rdata_z), .resp_cause(resp_cause_z),
    .bus_rw(bus_rw_z), .bus_len(bus_len_z), .bus_addr(bus_addr_z), .bus_write(bus_write_z),
    .bus_read(bus_read), .bus_exception(bus_exception)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    logic        ex;
    logic [1:0]  cause;
    logic [31:0] rdata;
    int          lat;
    int          rwc;
    logic [31:0] bw;
  } vec_t;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] rdata;
    int          lat;
    int          rwc;
    logic [31:0] bw;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from the size/alignment/extension rules using plain arithmetic.
  function automatic exp_t model(input int ws, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input logic ex);
    exp_t e;
    int nbytes;
    longint unsigned lim;
    longint v;
    nbytes = 1 << f3[1:0];
    e.rdata = 32'd0; e.bw = 32'd0; e.rwc = 0; e.lat = 1;
    if (f3[1:0] == 2'b11 || (st && f3[2])) begin
      e.cause = 2'b11;
      return e;
    end
    if ((a % nbytes) != 0) begin
      e.cause = 2'b01;
      return e;
    end
    lim   = 64'd1 << (8 * nbytes);
    e.bw  = 32'({32'd0, wd} % lim);
    e.lat = ws + 2;
    e.rwc = st ? ws + 1 : 0;
    if (ex) begin
      e.cause = 2'b10;
    end else begin
      e.cause = 2'b00;
      if (!st) begin
        v = longint'({32'd0, rd} % lim);
        if (!f3[2] && v >= longint'(lim / 2)) v = v - longint'(lim);
        e.rdata = 32'(v);
      end
    end
    return e;
  endfunction

  task automatic run_check(input string tag, input int ws, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input logic ex, input exp_t e);
    int lat, rwc;
    logic [31:0] rdata, bw, ba;
    logic [1:0] cause, bl;
    logic rdy_start, rdy_resp, rw_resp;
    @(negedge clk);
    rdy_start = (ws == 1) ? req_ready : req_ready_z;
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    bus_read = rd; bus_exception = ex;
    if (ws == 1) req_valid = 1'b1; else req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    lat = -1; rwc = 0; rdata = 'x; cause = 'x; bw = 'x; bl = 'x; ba = 'x;
    rdy_resp = 'x; rw_resp = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bw = (ws == 1) ? bus_write : bus_write_z;
        bl = (ws == 1) ? bus_len   : bus_len_z;
        ba = (ws == 1) ? bus_addr  : bus_addr_z;
      end
      if ((ws == 1) ? bus_rw : bus_rw_z) rwc++;
      if ((ws == 1) ? resp_valid : resp_valid_z) begin
        lat      = k;
        rdata    = (ws == 1) ? resp_rdata : resp_rdata_z;
        cause    = (ws == 1) ? resp_cause : resp_cause_z;
        rdy_resp = (ws == 1) ? req_ready  : req_ready_z;
        rw_resp  = (ws == 1) ? bus_rw     : bus_rw_z;
        break;
      end
    end
    chk({tag, " ready_before"}, 32'(rdy_start), 32'd1);
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " cause"}, 32'(cause), 32'(e.cause));
    chk({tag, " rdata"}, rdata, e.rdata);
    chk({tag, " rw_cycles"}, rwc, e.rwc);
    chk({tag, " ready_in_resp"}, 32'(rdy_resp), 32'd0);
    chk({tag, " rw_in_resp"}, 32'(rw_resp), 32'd0);
    if (e.lat > 1) begin
      chk({tag, " bus_write"}, bw, e.bw);
      chk({tag, " bus_len"}, 32'(bl), 32'(f3[1:0]));
      chk({tag, " bus_addr"}, ba, a);
    end
  endtask

  vec_t tbl[12];
  exp_t e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0; bus_read = 32'b0; bus_exception = 1'b0;

    tbl[0]  = '{1'b0, 3'b010, 32'h1000, 32'h0,        32'hDEADBEEF, 1'b0, 2'b00, 32'hDEADBEEF, 3, 0, 32'h0};
    tbl[1]  = '{1'b0, 3'b000, 32'h1003, 32'h0,        32'h00000080, 1'b0, 2'b00, 32'hFFFFFF80, 3, 0, 32'h0};
    tbl[2]  = '{1'b0, 3'b100, 32'h1003, 32'h0,        32'h00000080, 1'b0, 2'b00, 32'h00000080, 3, 0, 32'h0};
    tbl[3]  = '{1'b1, 3'b001, 32'h1002, 32'h12345678, 32'h0,        1'b0, 2'b00, 32'h0,        3, 2, 32'h00005678};
    tbl[4]  = '{1'b0, 3'b010, 32'h1001, 32'h0,        32'hDEADBEEF, 1'b0, 2'b01, 32'h0,        1, 0, 32'h0};
    tbl[5]  = '{1'b0, 3'b011, 32'h1000, 32'h0,        32'hDEADBEEF, 1'b0, 2'b11, 32'h0,        1, 0, 32'h0};
    tbl[6]  = '{1'b0, 3'b001, 32'h1000, 32'h0,        32'h00001234, 1'b1, 2'b10, 32'h0,        3, 0, 32'h0};
    tbl[7]  = '{1'b0, 3'b010, 32'h1004, 32'h0,        32'h11223344, 1'b0, 2'b00, 32'h11223344, 3, 0, 32'h0};
    tbl[8]  = '{1'b1, 3'b101, 32'h1001, 32'hAABBCCDD, 32'h0,        1'b0, 2'b11, 32'h0,        1, 0, 32'h0};
    tbl[9]  = '{1'b0, 3'b101, 32'h1002, 32'h0,        32'hFFFF8001, 1'b0, 2'b00, 32'h00008001, 3, 0, 32'h0};
    tbl[10] = '{1'b0, 3'b001, 32'h1002, 32'h0,        32'hFFFF8001, 1'b0, 2'b00, 32'hFFFF8001, 3, 0, 32'h0};
    tbl[11] = '{1'b1, 3'b000, 32'h1003, 32'hA5A5A5C3, 32'h0,        1'b1, 2'b10, 32'h0,        3, 2, 32'h000000C3};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_cause", 32'(resp_cause), 32'd0);
    chk("reset bus_rw", 32'(bus_rw), 32'd0);
    chk("reset bus_len", 32'(bus_len), 32'd0);
    chk("reset bus_addr", bus_addr, 32'd0);
    chk("reset bus_write", bus_write, 32'd0);

    foreach (tbl[i]) begin
      e.cause = tbl[i].cause; e.rdata = tbl[i].rdata; e.lat = tbl[i].lat;
      e.rwc = tbl[i].rwc; e.bw = tbl[i].bw;
      run_check($sformatf("vec%0d", i), 1, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd,
                tbl[i].rd, tbl[i].ex, e);
    end

    // Reset in the middle of a store access must abort it without a response.
    @(negedge clk);
    req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2000; req_wdata = 32'hCAFEF00D;
    bus_exception = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort rw_in_access", 32'(bus_rw), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort bus_rw", 32'(bus_rw), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("abort no_resp", seen, 0);

    e = '{2'b00, 32'hDEADBEEF, 2, 0, 32'h0};
    run_check("ws0 lw", 0, 1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0, e);

    for (int n = 0; n < 60; n++) begin
      logic        st, ex;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      int          ws;
      ws = (n % 3 == 2) ? 0 : 1;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h3000 + 32'($urandom_range(0, 7));
      wd = $urandom; rd = $urandom;
      ex = ($urandom_range(0, 3) == 0);
      run_check($sformatf("rnd%0d", n), ws, st, f3, a, wd, rd, ex, model(ws, st, f3, a, wd, rd, ex));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
